// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct and ALU encodings for the multicycle control unit.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_NONE  = 2'd3
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's ALU request plus the R-type funct field to an ALU operation.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  aluop_t             alu_op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [2:0]         alu_control_o
);

    logic [2:0] funct_op;

    always_comb begin
        funct_op = ALU_ADD;
        case (funct_i)
            FUNCT_W'(FN_SUB): funct_op = ALU_SUB;
            FUNCT_W'(FN_AND): funct_op = ALU_AND;
            FUNCT_W'(FN_OR):  funct_op = ALU_OR;
            FUNCT_W'(FN_SLT): funct_op = ALU_SLT;
            default:          funct_op = ALU_ADD;
        endcase
        // States that do not use the ALU drive an all-zero control word
        alu_control_o = alu_op_i == ALUOP_ADD ? ALU_ADD :
                        alu_op_i == ALUOP_SUB ? ALU_SUB :
                        alu_op_i == ALUOP_FUNCT ? funct_op : 3'b000;
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multicycle MIPS datapath.
// Define IMM_ARITH_EN to add the addi states ADDIEX/ADDIWB.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Mem_Ready,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic                PCWrite,
    output logic                Branch,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSrc,
    output logic [2:0]          ALU_Control,
    output logic [3:0]          State
);

    state_t state_q, state_d, cur;
    aluop_t alu_op;

    always_ff @(posedge clk) begin
        state_q <= reset ? S_FETCH : state_d;
    end

    // Outputs decode from FETCH while reset is high so enables stay quiet
    always_comb begin
        cur      = reset ? S_FETCH : state_q;
        state_d  = S_FETCH;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        alu_op   = ALUOP_NONE;
        case (cur)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_ADD;
                IRWrite = Mem_Ready & ~reset;
                PCWrite = Mem_Ready & ~reset;
                state_d = Mem_Ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                alu_op  = ALUOP_ADD;
                state_d = (Opcode == OPCODE_W'(OP_LW) || Opcode == OPCODE_W'(OP_SW)) ? S_MEMADR :
                          Opcode == OPCODE_W'(OP_RTYPE) ? S_EXECUTE :
                          Opcode == OPCODE_W'(OP_BEQ) ? S_BRANCH :
                          Opcode == OPCODE_W'(OP_J) ? S_JUMP : S_FETCH;
`ifdef IMM_ARITH_EN
                if (Opcode == OPCODE_W'(OP_ADDI)) state_d = S_ADDIEX;
`endif
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALUOP_ADD;
                state_d = Opcode == OPCODE_W'(OP_LW) ? S_MEMRD :
                          Opcode == OPCODE_W'(OP_SW) ? S_MEMWR : S_FETCH;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = Mem_Ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = Mem_Ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                Branch  = 1'b1;
                PCSrc   = 2'b01;
            end
`ifdef IMM_ARITH_EN
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALUOP_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
`endif
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: ;
        endcase
    end

    assign State = cur;

    alu_decoder #(.FUNCT_W(FUNCT_W)) u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (Funct),
        .alu_control_o (ALU_Control)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: vector table plus directed multi-cycle sequences for the control unit.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'h23;
    logic [5:0] Funct = 6'h20;
    logic       Mem_Ready = 1'b1;
    logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, Branch;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALU_Control;
    logic [3:0] State;

    int checks = 0;
    int failures = 0;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Mem_Ready(Mem_Ready),
        .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
        .Branch(Branch), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALU_Control(ALU_Control),
        .State(State)
    );

    always #5 clk = ~clk;

    // ctl = {IorD,IRWrite,MemWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,PCWrite,Branch,ALUSrcB,PCSrc,ALU_Control}
    localparam logic [15:0] C_F0   = 16'b000000000_0100_010;
    localparam logic [15:0] C_F1   = 16'b010000010_0100_010;
    localparam logic [15:0] C_DEC  = 16'b000000000_1100_010;
    localparam logic [15:0] C_MADR = 16'b000000100_1000_010;
    localparam logic [15:0] C_MRD  = 16'b100000000_0000_000;
    localparam logic [15:0] C_MWB  = 16'b000011000_0000_000;
    localparam logic [15:0] C_MWR  = 16'b101000000_0000_000;
    localparam logic [15:0] C_AWB  = 16'b000101000_0000_000;
    localparam logic [15:0] C_BR   = 16'b000000101_0001_110;
    localparam logic [15:0] C_J    = 16'b000000010_0010_000;
    localparam logic [15:0] C_AIWB = 16'b000001000_0000_000;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctl;
    } vec_t;

    vec_t vq[$];

    function automatic logic [15:0] ctl_now();
        return {IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, Branch,
                ALUSrcB, PCSrc, ALU_Control};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic mr, input logic [3:0] st, input logic [15:0] ctl);
        vq.push_back('{rst, op, fn, mr, st, ctl});
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [2:0] alu);
        add(0, 6'h00, fn, 1, 0, C_F1);
        add(0, 6'h00, fn, 1, 1, C_DEC);
        add(0, 6'h00, fn, 1, 6, {9'b000000100, 4'b0000, alu});
        add(0, 6'h00, fn, 1, 7, C_AWB);
    endtask

    task automatic run_count(input string name, input logic [5:0] op, input int exp);
        int c;
        Opcode = op;
        Funct = 6'h20;
        Mem_Ready = 1'b1;
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (State != 4'd0 && c < 20);
        check(name, 16'(c), 16'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        add(1, 6'h23, 6'h20, 1, 0, C_F0);
        add(1, 6'h23, 6'h20, 1, 0, C_F0);
        add(0, 6'h23, 6'h20, 1, 0, C_F1);
        add(0, 6'h23, 6'h20, 1, 1, C_DEC);
        add(0, 6'h23, 6'h20, 1, 2, C_MADR);
        add(0, 6'h23, 6'h20, 1, 3, C_MRD);
        add(0, 6'h23, 6'h20, 1, 4, C_MWB);
        add(0, 6'h2B, 6'h20, 0, 0, C_F0);
        add(0, 6'h2B, 6'h20, 1, 0, C_F1);
        add(0, 6'h2B, 6'h20, 1, 1, C_DEC);
        add(0, 6'h2B, 6'h20, 1, 2, C_MADR);
        add(0, 6'h2B, 6'h20, 0, 5, C_MWR);
        add(0, 6'h2B, 6'h20, 0, 5, C_MWR);
        add(0, 6'h2B, 6'h20, 0, 5, C_MWR);
        add(0, 6'h2B, 6'h20, 1, 5, C_MWR);
        rtype(6'h22, 3'b110);
        rtype(6'h24, 3'b000);
        rtype(6'h25, 3'b001);
        rtype(6'h2A, 3'b111);
        rtype(6'h3F, 3'b010);
        rtype(6'h20, 3'b010);
        add(0, 6'h3F, 6'h20, 1, 0, C_F1);
        add(0, 6'h3F, 6'h20, 1, 1, C_DEC);
        add(0, 6'h04, 6'h20, 1, 0, C_F1);
        add(0, 6'h04, 6'h20, 1, 1, C_DEC);
        add(0, 6'h04, 6'h20, 1, 8, C_BR);
        add(0, 6'h02, 6'h20, 1, 0, C_F1);
        add(0, 6'h02, 6'h20, 1, 1, C_DEC);
        add(0, 6'h02, 6'h20, 1, 11, C_J);
        add(0, 6'h08, 6'h20, 1, 0, C_F1);
        add(0, 6'h08, 6'h20, 1, 1, C_DEC);
`ifdef IMM_ARITH_EN
        add(0, 6'h08, 6'h20, 1, 9, C_MADR);
        add(0, 6'h08, 6'h20, 1, 10, C_AIWB);
`endif
        add(0, 6'h23, 6'h20, 1, 0, C_F1);
        add(0, 6'h23, 6'h20, 1, 1, C_DEC);
        add(0, 6'h23, 6'h20, 1, 2, C_MADR);
        add(1, 6'h23, 6'h20, 0, 0, C_F0);
        add(0, 6'h23, 6'h20, 0, 0, C_F0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset = vq[i].rst;
            Opcode = vq[i].op;
            Funct = vq[i].fn;
            Mem_Ready = vq[i].mr;
            #1;
            check($sformatf("v%0d_state", i), 16'(State), 16'(vq[i].st));
            check($sformatf("v%0d_ctl", i), ctl_now(), vq[i].ctl);
        end

        run_count("cycles_rtype", 6'h00, 4);
        run_count("cycles_lw", 6'h23, 5);
        run_count("cycles_sw", 6'h2B, 4);
        run_count("cycles_beq", 6'h04, 3);
        run_count("cycles_j", 6'h02, 3);
`ifdef IMM_ARITH_EN
        run_count("cycles_addi", 6'h08, 4);
`else
        run_count("cycles_addi", 6'h08, 2);
`endif

        Opcode = 6'h23;
        Mem_Ready = 1'b1;
        repeat (3) step();
        check("memrd_enter", 16'(State), 16'd3);
        Mem_Ready = 1'b0;
        repeat (3) step();
        check("memrd_hold", 16'(State), 16'd3);
        check("memrd_hold_rw", 16'(RegWrite), 16'd0);
        Mem_Ready = 1'b1;
        n = 0;
        while (State != 4'd4 && n < 5) begin
            step();
            n++;
        end
        check("memrd_to_memwb", 16'(State), 16'd4);
        check("memwb_rw", 16'(RegWrite), 16'd1);
        step();
        check("memwb_to_fetch", 16'(State), 16'd0);

        Opcode = 6'h2B;
        repeat (3) step();
        Mem_Ready = 1'b0;
        check("memwr_enter", 16'(State), 16'd5);
        check("memwr_mw", 16'(MemWrite), 16'd1);
        reset = 1'b1;
        #1;
        check("memwr_reset_mw", 16'(MemWrite), 16'd0);
        step();
        check("memwr_reset_state", 16'(State), 16'd0);
        reset = 1'b0;
        step();
        check("post_reset_hold", 16'(State), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode field width.
REQ-002 SHALL have parameter FUNCT_W, default 6, funct field width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Opcode  input  OPCODE_W  instr[31:26] from the instruction register.
REQ-006 SHALL have port Funct  input  FUNCT_W  instr[5:0].
REQ-007 SHALL have port Mem_Ready  input  1  memory access complete this cycle.
REQ-008 SHALL have ports IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, Branch  output  1 each  datapath mux selectors and enables.
REQ-009 SHALL have ports ALUSrcB, PCSrc  output  2 each  datapath mux selectors.
REQ-010 SHALL have port ALU_Control  output  3  ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-011 SHALL have port State  output  4  current state, debug only.

Function
REQ-012 SHALL be a Moore FSM; all outputs decode from current state only, except ALU_Control, which also uses Funct.
REQ-013 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-014 SHALL in FETCH assert IorD=0, ALUSrcA=0, ALUSrcB=01, ALU add, PCSrc=00; SHALL assert IRWrite and PCWrite only in the cycle Mem_Ready=1, then go to DECODE; with Mem_Ready=0 it SHALL hold FETCH with both deasserted.
REQ-015 SHALL in DECODE drive ALUSrcA=0, ALUSrcB=11, ALU add, then branch on Opcode: lw/sw(0x23/0x2B)->MEMADR, R-type(0x00)->EXECUTE, beq(0x04)->BRANCH, addi(0x08)->ADDIEX, j(0x02)->JUMP, any other->FETCH.
REQ-016 SHALL in MEMADR drive ALUSrcA=1, ALUSrcB=10, add; lw->MEMRD, sw->MEMWR.
REQ-017 SHALL in MEMRD drive IorD=1 and hold until Mem_Ready=1, then go to MEMWB.
REQ-018 SHALL in MEMWB assert RegWrite=1, RegDst=0, MemtoReg=1 for exactly one cycle, then go to FETCH.
REQ-019 SHALL in MEMWR drive IorD=1 and assert MemWrite each cycle until Mem_Ready=1, then go to FETCH.
REQ-020 SHALL in EXECUTE drive ALUSrcA=1, ALUSrcB=00, ALU_Control from Funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, other add), then go to ALUWB.
REQ-021 SHALL in ALUWB assert RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-022 SHALL in BRANCH drive ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSrc=01, then go to FETCH.
REQ-023 SHALL in JUMP assert PCWrite=1 with PCSrc=10, then go to FETCH.
REQ-024 SHALL drive every output not listed for a state to 0.
REQ-025 SHALL return to FETCH from any unused encoding (12-15) on the next edge.
REQ-026 SHALL give cycle counts with Mem_Ready tied high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, enter FETCH regardless of current state, including mid-access in MEMRD/MEMWR.
REQ-028 SHALL hold IRWrite, PCWrite, MemWrite and RegWrite at 0 and State at 0 while reset=1.

Configuration
REQ-029 SHALL support ADDI/ADDIEX/ADDIWB only when IMM_ARITH_EN is defined: ADDIEX drives ALUSrcA=1, ALUSrcB=10, add; ADDIWB asserts RegWrite=1, RegDst=0, MemtoReg=0.
REQ-030 SHALL, without IMM_ARITH_EN, omit states 9-10 and send opcode 0x08 from DECODE to FETCH.

Structure
REQ-031 SHALL take state encodings, opcode constants and funct constants from shared package mips_ctrl_pkg.
REQ-032 SHALL place Funct/ALUOp-to-ALU_Control decoding in sub-module alu_decoder.

Verification
REQ-033 SHALL test: reset held 2 cycles, then lw (0x23) with Mem_Ready=1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4.
REQ-034 SHALL test: sw with Mem_Ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-035 SHALL test: R-type Funct=0x22 -> ALU_Control=110 in EXECUTE; RegWrite=1, RegDst=1 in ALUWB.
REQ-036 SHALL test: Opcode 0x3F -> DECODE then FETCH, no write enable ever asserted.
REQ-037 SHALL test: reset=1 asserted during MEMRD -> next state 0, all enables 0.
REQ-038 SHALL test: addi (0x08) -> states 0,1,9,10,0 with IMM_ARITH_EN defined; 0,1,0 without it.
